sdram_cmd_exec: RTL

Command executor on the far side of the opcode FSM's select/start/done interface. It accepts a 4-bit select code and drives the SDRAM command pins, bank and address for one cycle. It then times the required NOP wait and returns a one-cycle done pulse. It also runs the power-up wait counter, which reports cnt_done while start is held, and produces data-path strobes for the read and write paths.

---
 rtl/sdram_pkg.sv | 61 ++++++
 rtl/sdram_cmd_exec_if.sv | 31 +++
 rtl/sdram_cmd_timer.sv | 28 ++
 rtl/sdram_cmd_exec.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM command executor.
// Holds select codes, pin encodings, mode-register fields and default timings.
package sdram_pkg;

    localparam int unsigned SEL_W  = 4;
    localparam int unsigned BANK_W = 2;
    localparam int unsigned ROW_W  = 13;
    localparam int unsigned COL_W  = 10;
    localparam int unsigned TMR_W  = 8;
    localparam int unsigned AP_BIT = 10;

    typedef enum logic [SEL_W-1:0] {
        NOP         = 4'd0,
        ACT         = 4'd1,
        READ        = 4'd2,
        READ_BURST  = 4'd3,
        WRITE       = 4'd4,
        WRITE_BURST = 4'd5,
        AREF        = 4'd6,
        SREF_ENTER  = 4'd7,
        SREF_EXIT   = 4'd8,
        PRE_ALL     = 4'd9,
        LMR         = 4'd10,
        LMR_BURST   = 4'd11
    } sel_e;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    typedef struct packed {
        logic cs_n;
        logic ras_n;
        logic cas_n;
        logic we_n;
    } cmd_pins_t;

    localparam cmd_pins_t PIN_DESEL = cmd_pins_t'(4'b1111);
    localparam cmd_pins_t PIN_NOP   = cmd_pins_t'(4'b0111);
    localparam cmd_pins_t PIN_ACT   = cmd_pins_t'(4'b0011);
    localparam cmd_pins_t PIN_READ  = cmd_pins_t'(4'b0101);
    localparam cmd_pins_t PIN_WRITE = cmd_pins_t'(4'b0100);
    localparam cmd_pins_t PIN_PRE   = cmd_pins_t'(4'b0010);
    localparam cmd_pins_t PIN_AREF  = cmd_pins_t'(4'b0001);
    localparam cmd_pins_t PIN_LMR   = cmd_pins_t'(4'b0000);

    // Mode-register fields: write mode, burst type, burst length codes
    localparam logic       MR_WB_BURST = 1'b0;
    localparam logic       MR_SEQ      = 1'b0;
    localparam logic [2:0] MR_BL1      = 3'b000;
    localparam logic [2:0] MR_BL8      = 3'b011;

    localparam int unsigned T_INIT_DEF    = 20000;
    localparam int unsigned T_RP_DEF      = 3;
    localparam int unsigned T_RCD_DEF     = 3;
    localparam int unsigned T_RFC_DEF     = 10;
    localparam int unsigned T_MRD_DEF     = 2;
    localparam int unsigned T_WR_DEF      = 2;
    localparam int unsigned T_XSR_DEF     = 12;
    localparam int unsigned CAS_LAT_DEF   = 3;
    localparam int unsigned BURST_LEN_DEF = 8;

endpackage

// File: rtl/sdram_cmd_exec_if.sv
// Select/start/done handshake plus SDRAM pin bundle of the command executor.
interface sdram_cmd_exec_if;
    import sdram_pkg::*;

    logic [SEL_W-1:0]  select;
    logic              start;
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row_addr;
    logic [COL_W-1:0]  col_addr;
    logic              done;
    logic              cnt_done;
    logic              cke;
    logic              cs_n;
    logic              ras_n;
    logic              cas_n;
    logic              we_n;
    logic [BANK_W-1:0] ba;
    logic [ROW_W-1:0]  addr;
    logic              dq_oe;
    logic              rd_valid;

    modport master (
        output select, start, bank, row_addr, col_addr,
        input  done, cnt_done, cke, cs_n, ras_n, cas_n, we_n, ba, addr, dq_oe, rd_valid
    );

    modport slave (
        input  select, start, bank, row_addr, col_addr,
        output done, cnt_done, cke, cs_n, ras_n, cas_n, we_n, ba, addr, dq_oe, rd_valid
    );
endinterface

// File: rtl/sdram_cmd_timer.sv
// Loadable saturating down-counter with a zero flag.
module sdram_cmd_timer
    import sdram_pkg::*;
#(
    parameter int unsigned W = TMR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         zero_c
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/sdram_cmd_exec.sv
// SDRAM command executor: issues one command per select code, times its
// NOP period, pulses done, and runs the power-up wait counter.
module sdram_cmd_exec
    import sdram_pkg::*;
#(
    parameter int unsigned T_INIT    = T_INIT_DEF,
    parameter int unsigned T_RP      = T_RP_DEF,
    parameter int unsigned T_RCD     = T_RCD_DEF,
    parameter int unsigned T_RFC     = T_RFC_DEF,
    parameter int unsigned T_MRD     = T_MRD_DEF,
    parameter int unsigned T_WR      = T_WR_DEF,
    parameter int unsigned T_XSR     = T_XSR_DEF,
    parameter int unsigned CAS_LAT   = CAS_LAT_DEF,
    parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
    input logic             clk,
    input logic             rst,
    sdram_cmd_exec_if.slave bus
);

    localparam int unsigned INIT_W = $clog2(T_INIT + 1);

    state_e            state, state_d;
    logic [SEL_W-1:0]  code, code_d;
    cmd_pins_t         pins, pins_d;
    logic [BANK_W-1:0] ba, ba_d;
    logic [ROW_W-1:0]  addr, addr_d;
    logic              cke, cke_d;
    logic              dq_oe, dq_oe_d;
    logic              rd_valid, rd_valid_d;
    logic              done, done_d;
    logic              issue;
    logic [TMR_W-1:0]  w_load, s_load, w_cnt, s_cnt, win_len;
    logic              w_zero, s_zero, win_on;
    logic [INIT_W-1:0] init_cnt;
    logic              cnt_done;

    sdram_cmd_timer #(.W(TMR_W)) u_wait_tmr (
        .clk(clk), .rst(rst), .load(issue), .load_val(w_load),
        .en(state != IDLE), .count(w_cnt), .zero_c(w_zero)
    );

    // Strobe window: active while the count lies in 1..win_len
    sdram_cmd_timer #(.W(TMR_W)) u_strobe_tmr (
        .clk(clk), .rst(rst), .load(issue), .load_val(s_load),
        .en(state != IDLE), .count(s_cnt), .zero_c(s_zero)
    );

    assign win_len = ((code == READ_BURST) || (code == WRITE_BURST)) ? TMR_W'(BURST_LEN) : TMR_W'(1);
    assign win_on  = !s_zero && (s_cnt <= win_len);

    always_comb begin
        state_d    = state;
        code_d     = code;
        pins_d     = PIN_NOP;
        ba_d       = '0;
        addr_d     = '0;
        cke_d      = cke;
        dq_oe_d    = 1'b0;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        issue      = 1'b0;
        w_load     = '0;
        s_load     = '0;
        unique case (state)
            IDLE: begin
                if (bus.select != '0) begin
                    issue   = 1'b1;
                    state_d = ISSUE;
                    code_d  = bus.select;
                    case (bus.select)
                        ACT: begin
                            pins_d = PIN_ACT;
                            ba_d   = bus.bank;
                            addr_d = bus.row_addr;
                            w_load = TMR_W'(T_RCD - 1);
                        end
                        READ, READ_BURST: begin
                            pins_d = PIN_READ;
                            ba_d   = bus.bank;
                            addr_d = {2'b00, 1'b1, bus.col_addr};
                            if (bus.select == READ) begin
                                w_load = TMR_W'(CAS_LAT + T_RP - 1);
                                s_load = TMR_W'(CAS_LAT);
                            end else begin
                                w_load = TMR_W'(CAS_LAT + BURST_LEN + T_RP - 2);
                                s_load = TMR_W'(CAS_LAT + BURST_LEN - 1);
                            end
                        end
                        WRITE, WRITE_BURST: begin
                            pins_d  = PIN_WRITE;
                            ba_d    = bus.bank;
                            addr_d  = {2'b00, 1'b1, bus.col_addr};
                            dq_oe_d = 1'b1;
                            if (bus.select == WRITE) begin
                                w_load = TMR_W'(T_WR + T_RP - 1);
                            end else begin
                                w_load = TMR_W'(BURST_LEN + T_WR + T_RP - 2);
                                s_load = TMR_W'(BURST_LEN - 1);
                            end
                        end
                        AREF: begin
                            pins_d = PIN_AREF;
                            w_load = TMR_W'(T_RFC - 1);
                        end
                        SREF_ENTER: begin
                            pins_d = PIN_AREF;
                            cke_d  = 1'b0;
                            w_load = TMR_W'(1);
                        end
                        SREF_EXIT: begin
                            cke_d  = 1'b1;
                            w_load = TMR_W'(T_XSR - 1);
                        end
                        PRE_ALL: begin
                            pins_d         = PIN_PRE;
                            addr_d[AP_BIT] = 1'b1;
                            w_load         = TMR_W'(T_RP - 1);
                        end
                        LMR, LMR_BURST: begin
                            pins_d = PIN_LMR;
                            addr_d = {3'b000, MR_WB_BURST, 2'b00, 3'(CAS_LAT), MR_SEQ,
                                      (bus.select == LMR) ? MR_BL1 : MR_BL8};
                            w_load = TMR_W'(T_MRD - 1);
                        end
                        default: w_load = '0;
                    endcase
                end
            end
            ISSUE, WAIT: begin
                rd_valid_d = win_on && ((code == READ) || (code == READ_BURST));
                dq_oe_d    = win_on && ((code == WRITE) || (code == WRITE_BURST));
                if (w_zero) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            code     <= '0;
            pins     <= PIN_DESEL;
            ba       <= '0;
            addr     <= '0;
            cke      <= 1'b1;
            dq_oe    <= 1'b0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            code     <= code_d;
            pins     <= pins_d;
            ba       <= ba_d;
            addr     <= addr_d;
            cke      <= cke_d;
            dq_oe    <= dq_oe_d;
            rd_valid <= rd_valid_d;
            done     <= done_d;
        end
    end

    // Power-up wait: saturating count while start is held
    always_ff @(posedge clk) begin
        if (rst || !bus.start) begin
            init_cnt <= '0;
            cnt_done <= 1'b0;
        end else begin
            if (init_cnt != INIT_W'(T_INIT)) begin
                init_cnt <= init_cnt + INIT_W'(1);
            end
            cnt_done <= (init_cnt >= INIT_W'(T_INIT - 1));
        end
    end

    assign bus.cs_n     = pins.cs_n;
    assign bus.ras_n    = pins.ras_n;
    assign bus.cas_n    = pins.cas_n;
    assign bus.we_n     = pins.we_n;
    assign bus.ba       = ba;
    assign bus.addr     = addr;
    assign bus.cke      = cke;
    assign bus.dq_oe    = dq_oe;
    assign bus.rd_valid = rd_valid;
    assign bus.done     = done;
    assign bus.cnt_done = cnt_done;

endmodule
